// File: rtl/sensor_input_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module   : sensor_input_conditioner_if
// Purpose  : Bundles the raw field-sensor inputs and the conditioned outputs
//            of sensor_input_conditioner.
// Ports    : raw_* (7)      unsynchronized switch / sensor levels
//            <level> (7)    debounced levels
//            change_strobe  one-cycle pulse per channel on accepted change,
//                           [0] low_water_level .. [6] selector
//            inputs_ready   startup window elapsed
// Modports : slave  - conditioner side (raw in, conditioned out)
//            master - environment side (raw out, conditioned in)
// Revision : 1.0 - initial release
// ============================================================================
interface sensor_input_conditioner_if;
  logic       raw_low_water_level;
  logic       raw_mid_water_level;
  logic       raw_high_water_level;
  logic       raw_earth_humidity;
  logic       raw_air_humidity;
  logic       raw_low_temperature;
  logic       raw_selector;

  logic       low_water_level;
  logic       mid_water_level;
  logic       high_water_level;
  logic       earth_humidity;
  logic       air_humidity;
  logic       low_temperature;
  logic       selector;
  logic [6:0] change_strobe;
  logic       inputs_ready;

  modport slave (
    input  raw_low_water_level, raw_mid_water_level, raw_high_water_level,
           raw_earth_humidity, raw_air_humidity, raw_low_temperature,
           raw_selector,
    output low_water_level, mid_water_level, high_water_level,
           earth_humidity, air_humidity, low_temperature, selector,
           change_strobe, inputs_ready
  );

  modport master (
    output raw_low_water_level, raw_mid_water_level, raw_high_water_level,
           raw_earth_humidity, raw_air_humidity, raw_low_temperature,
           raw_selector,
    input  low_water_level, mid_water_level, high_water_level,
           earth_humidity, air_humidity, low_temperature, selector,
           change_strobe, inputs_ready
  );
endinterface
`default_nettype wire

// File: rtl/sensor_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : sensor_input_conditioner
// Purpose  : Synchronizes and debounces seven field inputs (water-level
//            floats, humidity/temperature sensors, display selector). A new
//            level is accepted after DEBOUNCE_CYCLES consecutive differing
//            samples; any return to the stable value restarts the count.
// Ports    : clock    system clock, rising edge
//            reset_n  asynchronous active-low reset
//            sensors  sensor_input_conditioner_if.slave (raw in, levels,
//                     change_strobe and inputs_ready out)
// Params   : DEBOUNCE_CYCLES  acceptance threshold (2 .. 2^COUNTER_WIDTH-1)
//            COUNTER_WIDTH    debounce counter width
// Revision : 1.0 - initial release
// ============================================================================
module sensor_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int COUNTER_WIDTH   = 16
) (
  input  wire logic                 clock,
  input  wire logic                 reset_n,
  sensor_input_conditioner_if.slave sensors
);

  localparam int                     c_channels  = 7;
  localparam logic [COUNTER_WIDTH-1:0] c_cnt_last =
    COUNTER_WIDTH'(DEBOUNCE_CYCLES - 1);
  // One extra bit so DEBOUNCE_CYCLES+1 is representable even when
  // DEBOUNCE_CYCLES sits right below 2^COUNTER_WIDTH.
  localparam logic [COUNTER_WIDTH:0]   c_start_last =
    (COUNTER_WIDTH + 1)'(DEBOUNCE_CYCLES + 1);

  logic [c_channels-1:0] w_raw;
  logic [c_channels-1:0] r_sync1;
  logic [c_channels-1:0] r_sync2;
  logic [c_channels-1:0] w_stable;
  logic [c_channels-1:0] w_strobe;
  logic [COUNTER_WIDTH:0] r_start_cnt;
  logic                   r_ready;

  assign w_raw = {sensors.raw_selector,       sensors.raw_low_temperature,
                  sensors.raw_air_humidity,   sensors.raw_earth_humidity,
                  sensors.raw_high_water_level, sensors.raw_mid_water_level,
                  sensors.raw_low_water_level};

  // Two-flop synchronizer for every channel.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < c_channels; g++) begin : g_channel
    logic [COUNTER_WIDTH-1:0] r_cnt;
    logic                     r_stable;
    logic                     r_strobe;

    // The counter only advances while the sample disagrees with the stable
    // level; it is capped at c_cnt_last, where the new level is taken.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        r_cnt    <= '0;
        r_stable <= 1'b0;
        r_strobe <= 1'b0;
      end else begin
        r_strobe <= 1'b0;
        if (r_sync2[g] == r_stable) begin
          r_cnt <= '0;
        end else if (r_cnt == c_cnt_last) begin
          r_stable <= r_sync2[g];
          r_cnt    <= '0;
          r_strobe <= 1'b1;
        end else begin
          r_cnt <= r_cnt + COUNTER_WIDTH'(1);
        end
      end
    end

    assign w_stable[g] = r_stable;
    assign w_strobe[g] = r_strobe;
  end

  // Startup window: ready rises on the edge where the count reaches
  // DEBOUNCE_CYCLES+2, then the counter freezes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_start_cnt <= '0;
      r_ready     <= 1'b0;
    end else if (!r_ready) begin
      r_start_cnt <= r_start_cnt + (COUNTER_WIDTH + 1)'(1);
      if (r_start_cnt == c_start_last) begin
        r_ready <= 1'b1;
      end
    end
  end

  assign sensors.low_water_level  = w_stable[0];
  assign sensors.mid_water_level  = w_stable[1];
  assign sensors.high_water_level = w_stable[2];
  assign sensors.earth_humidity   = w_stable[3];
  assign sensors.air_humidity     = w_stable[4];
  assign sensors.low_temperature  = w_stable[5];
  assign sensors.selector         = w_stable[6];
  assign sensors.change_strobe    = w_strobe;
  assign sensors.inputs_ready     = r_ready;

endmodule
`default_nettype wire

// File: doc/sensor_input_conditioner.md
SENSOR_INPUT_CONDITIONER -- requirements
Module: sensor_input_conditioner

Interface
REQ-001 Parameters SHALL be: DEBOUNCE_CYCLES, default 50000, consecutive cycles a new level must persist before acceptance; COUNTER_WIDTH, default 16, debounce and startup counter width.
REQ-002 clock  input  1  single system clock; all state on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 raw_low_water_level, raw_mid_water_level, raw_high_water_level  input  1 each  unsynchronized water-level float switches.
REQ-005 raw_earth_humidity, raw_air_humidity, raw_low_temperature  input  1 each  unsynchronized field sensors.
REQ-006 raw_selector  input  1  unsynchronized operator display-selector switch.
REQ-007 low_water_level, mid_water_level, high_water_level, earth_humidity, air_humidity, low_temperature, selector  output  1 each  debounced levels feeding the irrigation controller top level.
REQ-008 change_strobe  output  7  one-cycle pulse per channel on accepted change; bit order [0] low_water_level through [6] selector, REQ-007 order.
REQ-009 inputs_ready  output  1  high once startup window has elapsed; downstream ignores levels while low.

Function
REQ-010 Each channel SHALL pass its raw input through a two-flop synchronizer; the second flop output is the channel sample.
REQ-011 Each channel SHALL hold a stable register (the REQ-007 output) and a COUNTER_WIDTH-bit debounce counter.
REQ-012 Sample equal to stable: counter SHALL clear to 0 on that edge.
REQ-013 Sample differing from stable and counter < DEBOUNCE_CYCLES-1: counter SHALL increment by 1.
REQ-014 Sample differing from stable and counter == DEBOUNCE_CYCLES-1: stable SHALL load the sample, counter SHALL clear, change_strobe bit SHALL be 1 for exactly that following cycle.
REQ-015 Latency SHALL be exactly DEBOUNCE_CYCLES+2 rising edges from the first edge capturing a clean new raw level to the output changing.
REQ-016 A raw pulse or glitch held for fewer than DEBOUNCE_CYCLES consecutive samples SHALL NOT change the output and SHALL leave the counter at 0 once the sample matches again.
REQ-017 Bouncing (sample toggling back to stable value mid-count) SHALL restart the count from 0; no partial credit retained.
REQ-018 Channels SHALL be fully independent; simultaneous changes on any subset produce simultaneous, independent acceptances and strobes.
REQ-019 Counters SHALL never exceed DEBOUNCE_CYCLES-1; no wrap-around is reachable. DEBOUNCE_CYCLES SHALL be >= 2 and < 2^COUNTER_WIDTH.
REQ-020 A startup counter SHALL count from reset release; inputs_ready SHALL rise on the edge the count reaches DEBOUNCE_CYCLES+2 and SHALL stay high until next reset.
REQ-021 Channels SHALL debounce normally during the startup window; strobes during the window SHALL still be emitted.
REQ-022 No combinational path SHALL exist from any raw input to any output.
REQ-023 The block SHALL NOT check water-level consistency; conflict detection stays downstream.

Reset
REQ-024 While reset_n is low: all synchronizer flops, stable registers, debounce counters and the startup counter SHALL be 0; all REQ-007 outputs, change_strobe = 7'b0000000, inputs_ready = 0.
REQ-025 Reset asserted mid-count or mid-strobe SHALL abort immediately; no pending acceptance survives reset.
REQ-026 After reset release, operation SHALL resume per REQ-010..REQ-021 from the reset state; reset release requires no synchronization inside this block.

Verification (DEBOUNCE_CYCLES = 4)
REQ-027 Reset released, all raw inputs 0 -> all outputs 0, no strobes, inputs_ready rises on edge 6 after release.
REQ-028 raw_high_water_level 0->1, held -> high_water_level = 1 exactly 6 edges later; change_strobe[2] high one cycle; other channels unchanged.
REQ-029 raw_earth_humidity pulsed high for 3 cycles, then low -> earth_humidity stays 0, no strobe.
REQ-030 raw_mid_water_level 1,1,0,1,1,1,1 bounce after 0 stable -> output rises only after 4 consecutive 1 samples following the dip.
REQ-031 raw_low_water_level and raw_selector rise on the same edge -> both outputs and strobe bits [0] and [6] assert on the same edge.
REQ-032 reset_n pulsed low when the count reaches 3 of 4 -> output remains 0, no strobe, counter 0; the change is then accepted 6 edges after release if the raw level is still held.
